// File: rtl/mimo_pkg.sv
// -----------------------------------------------------------------------------
// mimo_pkg
//   Shared constants and helpers for the 64-QAM MIMO soft-detector datapath.
//   W     : word width of R and Y samples (signed two's complement)
//   NANT  : antenna count, also the dimension of the upper-triangular R
//   NR    : number of stored R entries, NANT*(NANT+1)/2
//   tri_index(i,j) : packed slot of R entry (i,j), i<=j, 1-based, row-major
// -----------------------------------------------------------------------------
package mimo_pkg;

  localparam int W    = 12;
  localparam int NANT = 8;
  localparam int NR   = NANT * (NANT + 1) / 2;

  typedef logic [W-1:0] word_t;

  // Row i starts after (i-1) full rows that shrink by one entry each.
  function automatic int tri_index(input int i, input int j, input int n = NANT);
    return (i - 1) * n - ((i - 1) * (i - 2)) / 2 + (j - i);
  endfunction

endpackage

// File: rtl/mimo_tri_addr_gen.sv
// -----------------------------------------------------------------------------
// mimo_tri_addr_gen
//   Walks the R load order R(N,N), R(N-1,N-1), R(N-1,N), ... , R(1,1)..R(1,N)
//   one step per accepted beat and classifies each beat against the framing.
// Ports
//   clk, rstn      : clock, asynchronous active-low reset
//   beat           : a beat is handed over this cycle (valid && ready)
//   sof            : that beat carries the start-of-frame flag
//   start          : walk is at its start state (beat_cnt == 0)
//   advance        : beat is stored (everything except a dropped beat)
//   restart        : sof arrived while a frame was in progress
//   last           : beat completes the frame
//   wr_row/wr_col  : R coordinates the current beat writes to
//   wr_beat        : beat index the current beat occupies within the frame
// -----------------------------------------------------------------------------
module mimo_tri_addr_gen
  import mimo_pkg::*;
#(
  parameter  int NANT = mimo_pkg::NANT,
  localparam int NR   = NANT * (NANT + 1) / 2,
  localparam int RW   = $clog2(NANT + 1),
  localparam int BW   = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          beat,
  input  logic          sof,
  output logic          start,
  output logic          advance,
  output logic          restart,
  output logic          last,
  output logic [RW-1:0] wr_row,
  output logic [RW-1:0] wr_col,
  output logic [BW-1:0] wr_beat
);

  localparam logic [RW-1:0] EDGE      = RW'(NANT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NR - 1);

  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic [BW-1:0] beat_cnt;

  assign start   = (beat_cnt == '0);
  assign restart = beat && sof && !start;
  // A beat without sof while idle belongs to no frame and is not stored.
  assign advance = beat && (sof || !start);
  // sof on the final slot restarts the frame instead of completing it.
  assign last    = advance && !sof && (beat_cnt == LAST_BEAT);

  // An sof beat always lands on the first slot, whatever the walk held before.
  assign wr_row  = sof ? EDGE : row;
  assign wr_col  = sof ? EDGE : col;
  assign wr_beat = sof ? '0   : beat_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rstn) begin
      row      <= EDGE;
      col      <= EDGE;
      beat_cnt <= '0;
    end else if (last) begin
      row      <= EDGE;
      col      <= EDGE;
      beat_cnt <= '0;
    end else if (advance) begin
      // Reaching the right-hand edge moves up one row onto its diagonal.
      if (wr_col == EDGE) begin
        row <= wr_row - 1'b1;
        col <= wr_row - 1'b1;
      end else begin
        col <= wr_col + 1'b1;
      end
      beat_cnt <= wr_beat + 1'b1;
    end
  end

endmodule

// File: rtl/mimo_ry_frame_capture.sv
// -----------------------------------------------------------------------------
// mimo_ry_frame_capture
//   Captures one R/Y frame per handshake for the MIMO soft detector and holds
//   it in parallel until the detector takes it.
// Ports
//   clk, rstn          : clock, asynchronous active-low reset
//   in_valid, in_sof   : beat present / beat is beat 0 of a frame
//   in_ready           : beat accepted this cycle (low while a frame is held)
//   r1_in, r2_in       : lane-1/lane-2 R entry of the beat
//   y1_in, y2_in       : lane-1/lane-2 Y word (beats 0..NANT-1 only)
//   frame_valid        : full frame held on the flat outputs
//   frame_ready        : detector takes the frame
//   r1_flat, r2_flat   : R entry (i,j) at slice tri_index(i,j)*W
//   y1_flat, y2_flat   : y_k at slice (k-1)*W
//   err_frame          : one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module mimo_ry_frame_capture
  import mimo_pkg::*;
#(
  parameter  int W    = mimo_pkg::W,
  parameter  int NANT = mimo_pkg::NANT,
  localparam int NR   = NANT * (NANT + 1) / 2,
  localparam int RW   = $clog2(NANT + 1),
  localparam int BW   = $clog2(NR),
  localparam int YW   = $clog2(NANT)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic            in_sof,
  output logic            in_ready,
  input  logic [W-1:0]    r1_in,
  input  logic [W-1:0]    r2_in,
  input  logic [W-1:0]    y1_in,
  input  logic [W-1:0]    y2_in,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic [NR*W-1:0] r1_flat,
  output logic [NR*W-1:0] r2_flat,
  output logic [NANT*W-1:0] y1_flat,
  output logic [NANT*W-1:0] y2_flat,
  output logic            err_frame
);

  logic          beat;
  logic          start;
  logic          advance;
  logic          restart;
  logic          last;
  logic [RW-1:0] wr_row;
  logic [RW-1:0] wr_col;
  logic [BW-1:0] wr_beat;
  logic [BW-1:0] r_idx;
  logic [YW-1:0] y_idx;
  logic          y_we;

  logic [W-1:0] r1_bank [NR];
  logic [W-1:0] r2_bank [NR];
  logic [W-1:0] y1_bank [NANT];
  logic [W-1:0] y2_bank [NANT];

  // Holding a frame blocks the input, which also freezes the bank.
  assign in_ready = ~frame_valid;
  assign beat     = in_valid && in_ready;

  mimo_tri_addr_gen #(
    .NANT (NANT)
  ) u_addr (
    .clk     (clk),
    .rstn    (rstn),
    .beat    (beat),
    .sof     (in_sof),
    .start   (start),
    .advance (advance),
    .restart (restart),
    .last    (last),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_beat (wr_beat)
  );

  assign r_idx = BW'(tri_index(int'(wr_row), int'(wr_col), NANT));

  // Beat k carries y_(NANT-k), i.e. slot NANT-1-k; later beats carry no Y.
  always_comb begin
    // NOTE: defaults before the conditional keep this purely combinational;
    // an unassigned path would infer a latch.
    y_we  = 1'b0;
    y_idx = '0;
    if (advance && (wr_beat < BW'(NANT))) begin
      y_we  = 1'b1;
      y_idx = YW'(NANT - 1 - int'(wr_beat));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the bank drives the outputs directly and must read zero out of
      // reset, so unlike a plain storage RAM every entry is reset here.
      for (int i = 0; i < NR; i++) begin
        r1_bank[i] <= '0;
        r2_bank[i] <= '0;
      end
      for (int k = 0; k < NANT; k++) begin
        y1_bank[k] <= '0;
        y2_bank[k] <= '0;
      end
    end else if (advance) begin
      r1_bank[r_idx] <= r1_in;
      r2_bank[r_idx] <= r2_in;
      if (y_we) begin
        y1_bank[y_idx] <= y1_in;
        y2_bank[y_idx] <= y2_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_valid <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      // Restart discards the partial frame; a stray non-sof beat is dropped.
      err_frame <= restart || (beat && !in_sof && start);
      if (last) begin
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_r_flat
    assign r1_flat[gi*W +: W] = r1_bank[gi];
    assign r2_flat[gi*W +: W] = r2_bank[gi];
  end

  for (genvar gk = 0; gk < NANT; gk++) begin : g_y_flat
    assign y1_flat[gk*W +: W] = y1_bank[gk];
    assign y2_flat[gk*W +: W] = y2_bank[gk];
  end

endmodule

// File: tb/tb_mimo_ry_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_mimo_ry_frame_capture
//   Randomised bench with a beat-level reference model of the frame capture.
// -----------------------------------------------------------------------------
module tb_mimo_ry_frame_capture;
  import mimo_pkg::*;

  localparam int FW = NR * W;
  localparam int YF = NANT * W;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_sof, in_ready;
  logic [W-1:0]  r1_in, r2_in, y1_in, y2_in;
  logic          frame_valid, frame_ready, err_frame;
  logic [FW-1:0] r1_flat, r2_flat;
  logic [YF-1:0] y1_flat, y2_flat;

  mimo_ry_frame_capture dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .r1_in       (r1_in),
    .r2_in       (r2_in),
    .y1_in       (y1_in),
    .y2_in       (y2_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .r1_flat     (r1_flat),
    .r2_flat     (r2_flat),
    .y1_flat     (y1_flat),
    .y2_flat     (y2_flat),
    .err_frame   (err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int frame_c0 = 0;
  int err_seen = 0;
  int fv_pulses = 0;

  // beat_pos[k]: packed slot of the R entry carried by beat k.
  int beat_pos [NR];

  // Reference model state.
  logic         m_fv, m_err;
  int           m_cnt;
  logic [W-1:0] m_r1 [NR];
  logic [W-1:0] m_r2 [NR];
  logic [W-1:0] m_y1 [NANT];
  logic [W-1:0] m_y2 [NANT];

  // Frame stimulus buffers.
  logic [W-1:0] fr1 [NR];
  logic [W-1:0] fr2 [NR];
  logic [W-1:0] fy1 [NANT];
  logic [W-1:0] fy2 [NANT];

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Beat order R(N,N), R(N-1,N-1), R(N-1,N), ... mapped onto the row-major
  // upper-triangular packing R(1,1), R(1,2), ..., R(N,N).
  function automatic void build_tables();
    int slot [NANT+1][NANT+1];
    int n;
    int k;
    n = 0;
    for (int i = 1; i <= NANT; i++)
      for (int j = i; j <= NANT; j++) begin
        slot[i][j] = n;
        n++;
      end
    k = 0;
    for (int i = NANT; i >= 1; i--)
      for (int j = i; j <= NANT; j++) begin
        beat_pos[k] = slot[i][j];
        k++;
      end
  endfunction

  task automatic model_clear();
    m_fv  = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < NR; i++) begin
      m_r1[i] = '0;
      m_r2[i] = '0;
    end
    for (int i = 0; i < NANT; i++) begin
      m_y1[i] = '0;
      m_y2[i] = '0;
    end
  endtask

  // Reference model: advances once per clock on the beat semantics.
  initial begin
    build_tables();
    model_clear();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        model_clear();
      end else begin
        int k;
        m_err = 1'b0;
        if (m_fv) begin
          if (frame_ready) m_fv = 1'b0;
        end else if (in_valid) begin
          k = -1;
          if (in_sof) begin
            if (m_cnt != 0) m_err = 1'b1;
            k = 0;
          end else if (m_cnt == 0) begin
            m_err = 1'b1;
          end else begin
            k = m_cnt;
          end
          if (k >= 0) begin
            m_r1[beat_pos[k]] = r1_in;
            m_r2[beat_pos[k]] = r2_in;
            if (k < NANT) begin
              m_y1[NANT-1-k] = y1_in;
              m_y2[NANT-1-k] = y2_in;
            end
            if (k == NR - 1) begin
              m_fv  = 1'b1;
              m_cnt = 0;
            end else begin
              m_cnt = k + 1;
            end
          end
        end
      end
    end
  end

  // Compare process: every falling edge, DUT against the model.
  initial begin
    logic fv_prev;
    logic [FW-1:0] e1, e2;
    logic [YF-1:0] ey1, ey2;
    fv_prev = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        e1[i*W +: W] = m_r1[i];
        e2[i*W +: W] = m_r2[i];
      end
      for (int i = 0; i < NANT; i++) begin
        ey1[i*W +: W] = m_y1[i];
        ey2[i*W +: W] = m_y2[i];
      end
      check("in_ready", FW'(in_ready), FW'(!m_fv));
      check("frame_valid", FW'(frame_valid), FW'(m_fv));
      check("err_frame", FW'(err_frame), FW'(m_err));
      check("r1_flat", r1_flat, e1);
      check("r2_flat", r2_flat, e2);
      check("y1_flat", FW'(y1_flat), FW'(ey1));
      check("y2_flat", FW'(y2_flat), FW'(ey2));
      if (err_frame === 1'b1) err_seen++;
      if (frame_valid === 1'b1 && !fv_prev) fv_pulses++;
      fv_prev = frame_valid;
    end
  end

  task automatic send_beat(input logic sof, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_sof   = sof;
    r1_in    = a;
    r2_in    = b;
    y1_in    = c;
    y2_in    = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_in_time", FW'(acc), FW'(1));
    last_acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'($urandom);
    r1_in    = W'($urandom);
    r2_in    = W'($urandom);
    y1_in    = W'($urandom);
    y2_in    = W'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int gap_pct, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      if (k > 0 && int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(3, 1)));
      send_beat(k == 0, fr1[k], fr2[k],
                (k < NANT) ? fy1[k] : W'($urandom),
                (k < NANT) ? fy2[k] : W'($urandom));
      if (k == 0) frame_c0 = last_acc_cyc;
    end
  endtask

  task automatic wait_fv(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_valid_seen", FW'(frame_valid), FW'(1));
    c = cyc;
  endtask

  task automatic load_t1();
    for (int k = 0; k < NR; k++) begin
      fr1[k] = W'(k + 1);
      fr2[k] = W'(-(k + 1));
    end
    for (int k = 0; k < NANT; k++) begin
      fy1[k] = W'(100 + k);
      fy2[k] = W'(200 + k);
    end
  endtask

  task automatic load_rand();
    for (int k = 0; k < NR; k++) begin
      fr1[k] = W'($urandom);
      fr2[k] = W'($urandom);
    end
    for (int k = 0; k < NANT; k++) begin
      fy1[k] = W'($urandom);
      fy2[k] = W'($urandom);
    end
  endtask

  task automatic check_t1_slices(input string tag);
    check({tag, "_r1_88"}, FW'(r1_flat[35*W +: W]), FW'(12'd1));
    check({tag, "_r1_77"}, FW'(r1_flat[33*W +: W]), FW'(12'd2));
    check({tag, "_r1_78"}, FW'(r1_flat[34*W +: W]), FW'(12'd3));
    check({tag, "_r1_18"}, FW'(r1_flat[7*W +: W]), FW'(12'd36));
    check({tag, "_r2_18"}, FW'(r2_flat[7*W +: W]), FW'(12'hFDC));
    check({tag, "_y8"}, FW'(y1_flat[7*W +: W]), FW'(12'd100));
    check({tag, "_y1"}, FW'(y1_flat[0 +: W]), FW'(12'd107));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int c1;
    int e0;
    int p0;
    logic [FW-1:0] t1_r1;

    rstn        = 1'b0;
    in_valid    = 1'b0;
    in_sof      = 1'b0;
    r1_in       = '0;
    r2_in       = '0;
    y1_in       = '0;
    y2_in       = '0;
    frame_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", FW'(in_ready), FW'(1));
    check("rst_frame_valid", FW'(frame_valid), FW'(0));
    check("rst_err", FW'(err_frame), FW'(0));
    check("rst_r1_flat", r1_flat, '0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // T1: single back-to-back frame, detector not ready yet.
    load_t1();
    for (int k = 0; k < NR; k++) t1_r1[beat_pos[k]*W +: W] = fr1[k];
    send_frame(0, NR);
    wait_fv(c1);
    check("t1_fv_latency", FW'(c1 - frame_c0), FW'(NR - 1));
    check_t1_slices("t1");

    // T2: backpressure with extra beats offered while the frame is held.
    for (int n = 0; n < 20; n++) begin
      in_valid = 1'b1;
      in_sof   = 1'($urandom);
      r1_in    = W'($urandom);
      r2_in    = W'($urandom);
      y1_in    = W'($urandom);
      y2_in    = W'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_in_ready_low", FW'(in_ready), FW'(0));
    check("t2_fv_held", FW'(frame_valid), FW'(1));
    check("t2_r1_held", r1_flat, t1_r1);
    check_t1_slices("t2");
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_fv_released", FW'(frame_valid), FW'(0));
    check("t2_in_ready_back", FW'(in_ready), FW'(1));
    @(posedge clk);
    #1;

    // T3: restart after 11 beats, then a full frame.
    e0 = err_seen;
    load_rand();
    send_frame(0, 11);
    load_rand();
    send_frame(0, NR);
    idle(4);
    check("t3_err_pulses", FW'(err_seen - e0), FW'(1));

    // T4: reset, then a beat without sof, then a proper frame.
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    e0 = err_seen;
    send_beat(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    idle(2);
    check("t4_err_pulses", FW'(err_seen - e0), FW'(1));
    load_rand();
    send_frame(0, NR);
    idle(3);

    // T5: gapped frame with T1 data, then reset in the middle of a frame.
    frame_ready = 1'b0;
    load_t1();
    send_frame(40, NR);
    wait_fv(c1);
    check("t5_r1_full", r1_flat, t1_r1);
    check_t1_slices("t5");
    frame_ready = 1'b1;
    idle(2);
    load_rand();
    send_frame(40, 20);
    rstn = 1'b0;
    @(negedge clk);
    check("t5_rst_fv", FW'(frame_valid), FW'(0));
    check("t5_rst_in_ready", FW'(in_ready), FW'(1));
    check("t5_rst_err", FW'(err_frame), FW'(0));
    check("t5_rst_r1", r1_flat, '0);
    check("t5_rst_y1", FW'(y1_flat), '0);
    rstn = 1'b1;
    idle(2);
    load_rand();
    send_frame(30, NR);
    idle(3);

    // T6: three streamed frames with the detector always ready.
    p0 = fv_pulses;
    for (int f = 0; f < 3; f++) begin
      load_rand();
      send_frame(0, NR);
    end
    idle(5);
    check("t6_fv_pulses", FW'(fv_pulses - p0), FW'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
